// File: rtl/isp_pkg.sv
// Shared ISP definitions: raw-capture FSM encoding and compile-time helpers.
package isp_pkg;

  typedef enum logic [1:0] {
    CAP_WAIT_SOF = 2'd0,
    CAP_SKIP     = 2'd1,
    CAP_RUN      = 2'd2
  } cap_state_t;

  // Right shift that turns a camera sample into an output sample.
  function automatic int cap_round_shift(input int src_bits, input int out_bits);
    return src_bits - out_bits;
  endfunction

  // Counter width with headroom above max_val, so that the saturated value never
  // looks like it is inside the crop window.
  function automatic int cap_cnt_width(input int max_val);
    return $clog2(max_val + 2);
  endfunction

endpackage

// File: rtl/isp_raw_capture_if.sv
// Camera DVP input bus plus the cropped/rounded stream that feeds the pipeline head.
interface isp_raw_capture_if #(
  parameter int SRC_BITS = 10,
  parameter int OUT_BITS = 8
);
  logic                cam_vsync;
  logic                cam_href;
  logic [SRC_BITS-1:0] cam_data;
  logic                out_vsync;
  logic                out_hsync;
  logic                out_den;
  logic [OUT_BITS-1:0] out_data;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  out_vsync, out_hsync, out_den, out_data
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output out_vsync, out_hsync, out_den, out_data
  );
endinterface

// File: rtl/isp_raw_capture.sv
// Raw Bayer capture: frame skipping, fixed-window crop and rounding to the pipeline width.
module isp_raw_capture
  import isp_pkg::*;
#(
  parameter int SRC_BITS    = 10,
  parameter int OUT_BITS    = 8,
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 1024,
  parameter int H_OFFSET    = 0,
  parameter int V_OFFSET    = 0,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  isp_raw_capture_if.slave      cap,
  output logic [15:0]           frame_cnt,
  output logic                  short_line,
  output logic                  short_frame
);

  localparam int SHIFT = cap_round_shift(SRC_BITS, OUT_BITS);
  localparam int H_END = H_OFFSET + H_ACTIVE;
  localparam int V_END = V_OFFSET + V_ACTIVE;
  localparam int COL_W = cap_cnt_width(H_END);
  localparam int ROW_W = cap_cnt_width(V_END);

  localparam logic [COL_W-1:0] COL_LO  = COL_W'(H_OFFSET);
  localparam logic [COL_W-1:0] COL_LEN = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_HI  = COL_W'(H_END);
  localparam logic [COL_W-1:0] COL_MAX = '1;
  localparam logic [ROW_W-1:0] ROW_LO  = ROW_W'(V_OFFSET);
  localparam logic [ROW_W-1:0] ROW_LEN = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_HI  = ROW_W'(V_END);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;
  localparam logic [3:0]       SKIP_INIT = 4'(SKIP_FRAMES);

  // Stage 1: registered camera bus plus previous levels for edge detection
  logic                vsync_s1_reg, href_s1_reg;
  logic                vsync_prev_reg, href_prev_reg;
  logic [SRC_BITS-1:0] data_s1_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_s1_reg   <= 1'b0;
      href_s1_reg    <= 1'b0;
      vsync_prev_reg <= 1'b0;
      href_prev_reg  <= 1'b0;
      data_s1_reg    <= '0;
    end else begin
      vsync_s1_reg   <= cap.cam_vsync;
      href_s1_reg    <= cap.cam_href;
      vsync_prev_reg <= vsync_s1_reg;
      href_prev_reg  <= href_s1_reg;
      data_s1_reg    <= cap.cam_data;
    end
  end

  logic sof, eol;
  assign sof = vsync_s1_reg & ~vsync_prev_reg;
  assign eol = ~href_s1_reg & href_prev_reg;

  logic [OUT_BITS-1:0] data_round;

  generate
    if (SHIFT == 0) begin : g_pass
      assign data_round = data_s1_reg;
    end else begin : g_round
      localparam logic [SRC_BITS:0] HALF = (SRC_BITS+1)'(1) << (SHIFT - 1);
      localparam logic [SRC_BITS:0] OMAX = (SRC_BITS+1)'((1 << OUT_BITS) - 1);
      logic [SRC_BITS:0] sum, shifted;
      assign sum        = {1'b0, data_s1_reg} + HALF;
      assign shifted    = sum >> SHIFT;
      assign data_round = (shifted > OMAX) ? '1 : shifted[OUT_BITS-1:0];
    end
  endgenerate

  cap_state_t       state_reg, state_next;
  logic [3:0]       skip_reg, skip_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next, row_eol;
  logic [15:0]      frame_cnt_reg, frame_cnt_next;
  logic             out_vsync_reg, out_den_reg, short_line_reg, short_frame_reg;
  logic [OUT_BITS-1:0] out_data_reg;
  logic             in_row, in_col, pass, vsync_gate, short_line_next, short_frame_next;

  always_comb begin
    state_next       = state_reg;
    skip_next        = skip_reg;
    col_next         = col_reg;
    row_next         = row_reg;
    row_eol          = row_reg;
    frame_cnt_next   = frame_cnt_reg;
    short_line_next  = 1'b0;
    short_frame_next = 1'b0;

    // Unsigned wrap makes one compare cover both window bounds
    in_row = (row_reg - ROW_LO) < ROW_LEN;
    in_col = (col_reg - COL_LO) < COL_LEN;
    pass   = (state_reg == CAP_RUN) && href_s1_reg && in_row && in_col;

    if (href_s1_reg) begin
      col_next = (col_reg == COL_MAX) ? col_reg : col_reg + COL_W'(1);
    end else if (eol) begin
      col_next = '0;
    end

    if (eol) begin
      row_eol = (row_reg == ROW_MAX) ? row_reg : row_reg + ROW_W'(1);
      if ((state_reg == CAP_RUN) && in_row && (col_reg < COL_HI)) begin
        short_line_next = 1'b1;
      end
    end
    row_next = row_eol;

    // The EOL of a coincident line end is already folded into row_eol
    if (sof) begin
      row_next = '0;
      case (state_reg)
        CAP_WAIT_SOF: begin
          if (enable) begin
            state_next = (SKIP_INIT == 4'd0) ? CAP_RUN : CAP_SKIP;
            skip_next  = SKIP_INIT;
          end
        end
        CAP_SKIP: begin
          if (!enable) begin
            state_next = CAP_WAIT_SOF;
            skip_next  = '0;
          end else if (skip_reg <= 4'd1) begin
            state_next = CAP_RUN;
            skip_next  = '0;
          end else begin
            skip_next = skip_reg - 4'd1;
          end
        end
        CAP_RUN: begin
          if (row_eol >= ROW_HI) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
          end else begin
            short_frame_next = 1'b1;
          end
          if (!enable) begin
            state_next = CAP_WAIT_SOF;
          end
        end
        default: state_next = CAP_WAIT_SOF;
      endcase
    end

    vsync_gate = vsync_s1_reg && (state_next == CAP_RUN);
  end

  // Stage 2: FSM, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= CAP_WAIT_SOF;
      skip_reg        <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      frame_cnt_reg   <= '0;
      out_vsync_reg   <= 1'b0;
      out_den_reg     <= 1'b0;
      out_data_reg    <= '0;
      short_line_reg  <= 1'b0;
      short_frame_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      skip_reg        <= skip_next;
      col_reg         <= col_next;
      row_reg         <= row_next;
      frame_cnt_reg   <= frame_cnt_next;
      out_vsync_reg   <= vsync_gate;
      out_den_reg     <= pass;
      out_data_reg    <= pass ? data_round : '0;
      short_line_reg  <= short_line_next;
      short_frame_reg <= short_frame_next;
    end
  end

  assign cap.out_vsync = out_vsync_reg;
  assign cap.out_hsync = out_den_reg;
  assign cap.out_den   = out_den_reg;
  assign cap.out_data  = out_data_reg;
  assign frame_cnt     = frame_cnt_reg;
  assign short_line    = short_line_reg;
  assign short_frame   = short_frame_reg;

endmodule
